// File: rtl/crc16_rx_pkg.sv
// rtl/crc16_rx_pkg.sv - shared types and constants for the receive-side CRC16 checker
package crc16_rx_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;

  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  localparam logic [3:0] OP_SELECT_HI = 4'b1010;
  localparam logic [7:0] OP_REQRN     = 8'hC1;
  localparam logic [7:0] OP_READ      = 8'hC2;
  localparam logic [7:0] OP_WRITE     = 8'hC3;
  localparam logic [7:0] OP_SENSDATA  = 8'hE0;

  localparam int MIN_CRC16_BITS = 24;

  function automatic logic crc16_applies(input logic [7:0] op);
    return (op[7:4] == OP_SELECT_HI) || (op == OP_REQRN) || (op == OP_READ) ||
           (op == OP_WRITE) || (op == OP_SENSDATA);
  endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// rtl/crc16_lfsr.sv - serial CRC-16/CCITT shift engine, shared with the TX-side generator
module crc16_lfsr
  import crc16_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        preset,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] base;
  logic        fb;

  // A preset and a bit in the same cycle shift the bit into the fresh preset value.
  always_comb begin
    base  = preset ? CRC16_PRESET : crc_q;
    fb    = din ^ base[15];
    crc_d = base;
    if (en) begin
      crc_d = {base[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC16_PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc16_rx_ctrl.sv
// rtl/crc16_rx_ctrl.sv - frame sequencer: opcode capture, CRC16 applicability and registered verdict
module crc16_rx_ctrl
  import crc16_rx_pkg::*;
#(
  parameter int MAX_BITS = 512,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_end,
  input  logic             force_crc16,
  output logic             busy,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             crc_na,
  output logic [7:0]       opcode,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_CRC16_BITS);
  localparam logic [CNT_W-1:0] OP_BITS = CNT_W'(8);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [7:0]       opcode_q, opcode_d;
  logic             force_q, force_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             na_q, na_d;
  logic             accept;
  logic             applies;
  logic             len_err;
  logic [15:0]      crc;

  assign applies = force_q || crc16_applies(opcode_q);
  // A saturated counter means the frame overran the limit, so it is a length error too.
  assign len_err = (bit_count_q < MIN_CNT) || (bit_count_q == MAX_CNT);

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    opcode_d    = opcode_q;
    force_d     = force_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    err_d       = err_q;
    na_d        = na_q;
    accept      = 1'b0;

    if (frame_start) begin
      state_d     = RUN;
      bit_count_d = '0;
      opcode_d    = 8'h00;
      force_d     = force_crc16;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      na_d        = 1'b0;
      accept      = bit_valid;
    end else begin
      case (state_q)
        RUN: begin
          accept = bit_valid;
          if (frame_end) state_d = CHECK;
        end
        CHECK: begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!applies) begin
            na_d = 1'b1;
          end else if (len_err) begin
            err_d = 1'b1;
          end else begin
            ok_d  = (crc == CRC16_RESIDUE);
            err_d = (crc != CRC16_RESIDUE);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      if (bit_count_d < OP_BITS) opcode_d[3'd7 - bit_count_d[2:0]] = bit_in;
      if (bit_count_d != MAX_CNT) bit_count_d = bit_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      opcode_q    <= 8'h00;
      force_q     <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      na_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      opcode_q    <= opcode_d;
      force_q     <= force_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      na_q        <= na_d;
    end
  end

  crc16_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .preset  (frame_start),
    .en      (accept),
    .din     (bit_in),
    .crc     (crc)
  );

  assign busy      = (state_q != IDLE);
  assign crc_done  = done_q;
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign crc_na    = na_q;
  assign opcode    = opcode_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_crc16_rx_ctrl.sv
// tb/tb_crc16_rx_ctrl.sv - directed self-checking bench for crc16_rx_ctrl
module tb_crc16_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       frame_end = 1'b0;
  logic       force_crc16 = 1'b0;
  logic       busy, crc_done, crc_ok, crc_err, crc_na;
  logic [7:0] opcode;
  logic [9:0] bit_count;

  int   total = 0;
  int   bad = 0;
  int   done_pulses = 0;
  logic fq[$];

  crc16_rx_ctrl #(.MAX_BITS(512), .CNT_W(10)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .frame_end   (frame_end),
    .force_crc16 (force_crc16),
    .busy        (busy),
    .crc_done    (crc_done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .crc_na      (crc_na),
    .opcode      (opcode),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (crc_done === 1'b1) done_pulses++;

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) fq.push_back(b[i]);
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) fq.push_back(w[i]);
  endtask

  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = fq[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic push_good;
    string s;
    s = "123456789";
    fq.delete();
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    push_word(16'hD64E);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_partial(input int n);
    @(negedge clk);
    frame_start = 1'b1;
    force_crc16 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      bit_valid   = 1'b1;
      bit_in      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  // Sends fq as one frame (with a strobe gap every fifth bit); lat = cycles from frame_end to crc_done.
  task automatic run_frame(input logic f, input bit with_last, output int lat);
    int n;
    n   = fq.size();
    lat = 0;
    @(negedge clk);
    frame_start = 1'b1;
    force_crc16 = f;
    bit_valid   = 1'b0;
    frame_end   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (i % 5 == 3) begin
        bit_valid = 1'b0;
        @(negedge clk);
      end
      bit_valid = 1'b1;
      bit_in    = fq[i];
      if (with_last && i == n - 1) frame_end = 1'b1;
    end
    if (!with_last) begin
      @(negedge clk);
      bit_valid = 1'b0;
      frame_end = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      frame_end = 1'b0;
      if (crc_done === 1'b1 && lat == 0) lat = k;
    end
  endtask

  task automatic test_reset;
    idle(2);
    total++;
    if ({busy, crc_done, crc_ok, crc_err, crc_na} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, crc_done, crc_ok, crc_err, crc_na});
    end
    total++;
    if ({opcode, bit_count} !== 18'h0) begin
      bad++;
      $display("FAIL reset_opcode_count: got %h/%0d expected 00/0", opcode, bit_count);
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_force_good;
    int lat;
    push_good();
    run_frame(1'b1, 1'b0, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL good_latency: got %0d expected 2", lat); end
    total++;
    if ({crc_ok, crc_err, crc_na} !== 3'b100) begin
      bad++; $display("FAIL good_verdict: got %b expected 100", {crc_ok, crc_err, crc_na});
    end
    total++;
    if (bit_count !== 10'd88) begin bad++; $display("FAIL good_count: got %0d expected 88", bit_count); end
    total++;
    if (opcode !== 8'h31) begin bad++; $display("FAIL good_opcode: got %h expected 31", opcode); end
    idle(3);
    total++;
    if ({busy, crc_ok} !== 2'b01) begin
      bad++; $display("FAIL good_hold: got busy,ok=%b expected 01", {busy, crc_ok});
    end
  endtask

  task automatic test_bad_bits;
    int lat;
    push_good();
    fq[40] = ~fq[40];
    run_frame(1'b1, 1'b0, lat);
    total++;
    if ({crc_ok, crc_err} !== 2'b01) begin
      bad++; $display("FAIL data_flip: got ok,err=%b expected 01", {crc_ok, crc_err});
    end
    push_good();
    fq[80] = ~fq[80];
    run_frame(1'b1, 1'b0, lat);
    total++;
    if ({crc_ok, crc_err} !== 2'b01) begin
      bad++; $display("FAIL crc_flip: got ok,err=%b expected 01", {crc_ok, crc_err});
    end
  endtask

  task automatic test_reqrn;
    int          lat;
    logic [15:0] c;
    fq.delete();
    push_byte(8'hC1);
    push_word(16'hA5A5);
    c = model_crc(24);
    push_word(~c);
    run_frame(1'b0, 1'b0, lat);
    total++;
    if ({crc_ok, crc_err, crc_na} !== 3'b100) begin
      bad++; $display("FAIL reqrn_verdict: got %b expected 100", {crc_ok, crc_err, crc_na});
    end
    total++;
    if ({opcode, bit_count} !== {8'hC1, 10'd40}) begin
      bad++; $display("FAIL reqrn_fields: got %h/%0d expected c1/40", opcode, bit_count);
    end
  endtask

  task automatic test_query;
    int lat;
    fq.delete();
    push_byte(8'h80);
    push_byte(8'h3C);
    fq.push_back(1'b1);
    fq.push_back(1'b0);
    run_frame(1'b0, 1'b0, lat);
    total++;
    if ({crc_ok, crc_err, crc_na} !== 3'b001) begin
      bad++; $display("FAIL query_verdict: got %b expected 001", {crc_ok, crc_err, crc_na});
    end
    total++;
    if ({opcode, bit_count} !== {8'h80, 10'd18}) begin
      bad++; $display("FAIL query_fields: got %h/%0d expected 80/18", opcode, bit_count);
    end
  endtask

  task automatic test_length;
    int lat;
    fq.delete();
    push_word(16'h1234);
    run_frame(1'b1, 1'b0, lat);
    total++;
    if ({crc_ok, crc_err, crc_na} !== 3'b010) begin
      bad++; $display("FAIL short_verdict: got %b expected 010", {crc_ok, crc_err, crc_na});
    end
    fq.delete();
    for (int i = 0; i < 517; i++) fq.push_back(1'($urandom_range(0, 1)));
    run_frame(1'b1, 1'b0, lat);
    total++;
    if (bit_count !== 10'd512) begin bad++; $display("FAIL sat_count: got %0d expected 512", bit_count); end
    total++;
    if ({crc_ok, crc_err} !== 2'b01) begin
      bad++; $display("FAIL sat_verdict: got ok,err=%b expected 01", {crc_ok, crc_err});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int d0;
    d0 = done_pulses;
    start_partial(20);
    push_good();
    run_frame(1'b1, 1'b0, lat);
    idle(2);
    total++;
    if (done_pulses - d0 !== 1) begin
      bad++; $display("FAIL abort_pulses: got %0d expected 1", done_pulses - d0);
    end
    total++;
    if ({lat, crc_ok} !== {32'd2, 1'b1}) begin
      bad++; $display("FAIL abort_verdict: got lat=%0d ok=%b expected 2/1", lat, crc_ok);
    end
    push_good();
    run_frame(1'b1, 1'b1, lat);
    total++;
    if ({lat, crc_ok, crc_err, bit_count} !== {32'd2, 1'b1, 1'b0, 10'd88}) begin
      bad++;
      $display("FAIL end_with_last: got lat=%0d ok=%b err=%b cnt=%0d expected 2/1/0/88",
               lat, crc_ok, crc_err, bit_count);
    end
    d0 = done_pulses;
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    idle(3);
    total++;
    if ({busy, 32'(done_pulses - d0)} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL idle_end: got busy=%b pulses=%0d expected 0/0", busy, done_pulses - d0);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int d0;
    d0 = done_pulses;
    start_partial(30);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, crc_done, crc_ok, crc_err, crc_na, opcode, bit_count} !== 23'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b %h %0d expected all 0",
               {busy, crc_done, crc_ok, crc_err, crc_na}, opcode, bit_count);
    end
    idle(2);
    reset_n = 1'b1;
    idle(2);
    total++;
    if (done_pulses - d0 !== 0) begin
      bad++; $display("FAIL mid_reset_pulses: got %0d expected 0", done_pulses - d0);
    end
    push_good();
    run_frame(1'b1, 1'b0, lat);
    total++;
    if ({lat, crc_ok, crc_err} !== {32'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL post_reset_frame: got lat=%0d ok=%b err=%b expected 2/1/0", lat, crc_ok, crc_err);
    end
  endtask

  initial begin
    test_reset();
    test_force_good();
    test_bad_bits();
    test_reqrn();
    test_query();
    test_length();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
